// File: rtl/maxnet_pkg.sv
// Shared types for the max-pooling path: pixel type, sequencer states, max helper.
// Latency: n/a (types only); backpressure: n/a.
package maxnet_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LAST,
        OUT,
        DONE
    } state_t;

    // Ties keep the incumbent, so a later equal pixel never replaces the running max.
    function automatic pixel_t pixel_max(input pixel_t cur, input pixel_t cand);
        return (cand > cur) ? cand : cur;
    endfunction

endpackage

// File: rtl/maxpool_addr_gen.sv
// Window/tap counters and row-major address generation for the pooling sequencer.
// Latency: address is combinational from the counters; backpressure: counters only move on tap_adv / win_adv.
module maxpool_addr_gen
    import maxnet_pkg::*;
#(
    parameter int N  = 5,
    parameter int K  = 2,
    parameter int AW = $clog2(N * N),
    parameter int OW = $clog2(N / K) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tap_adv,
    input  logic          win_adv,
    output logic [AW-1:0] rd_addr,
    output logic [OW-1:0] wr,
    output logic [OW-1:0] wc,
    output logic          first_tap,
    output logic          last_tap,
    output logic          last_win
);

    localparam int NW = N / K;
    localparam int KW = $clog2(K) + 1;
    localparam logic [KW-1:0] KLAST = KW'(K - 1);
    localparam logic [OW-1:0] WLAST = OW'(NW - 1);
    localparam logic [31:0] K32 = K;
    localparam logic [31:0] N32 = N;

    logic [KW-1:0] ky;
    logic [KW-1:0] kx;
    logic          last_kx;
    logic          last_wc;

    always_comb begin
        last_kx   = (kx == KLAST);
        last_tap  = last_kx && (ky == KLAST);
        first_tap = (kx == '0) && (ky == '0);
        last_wc   = (wc == WLAST);
        last_win  = last_wc && (wr == WLAST);
    end

    // Rows and columns past NW*K are never reached, so the trailing N mod K strip is skipped.
    assign rd_addr = AW'((32'(wr) * K32 + 32'(ky)) * N32 + 32'(wc) * K32 + 32'(kx));

    always_ff @(posedge clk) begin
        if (!rst) begin
            ky <= '0;
            kx <= '0;
            wr <= '0;
            wc <= '0;
        end else begin
            if (tap_adv) begin
                if (last_kx) begin
                    kx <= '0;
                    ky <= last_tap ? '0 : ky + KW'(1);
                end else begin
                    kx <= kx + KW'(1);
                end
            end
            if (win_adv) begin
                if (last_wc) begin
                    wc <= '0;
                    wr <= (wr == WLAST) ? '0 : wr + OW'(1);
                end else begin
                    wc <= wc + OW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/maxpool_sched.sv
// Walks an NxN pixel RAM in KxK windows, one read per cycle, and streams each window maximum.
// Latency: K*K+2 cycles per window; backpressure: OUT holds data/row/col stable until out_ready.
module maxpool_sched
    import maxnet_pkg::*;
#(
    parameter int N  = 5,
    parameter int K  = 2,
    parameter int AW = $clog2(N * N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  pixel_t               rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output pixel_t               out_data,
    output logic [$clog2(N/K):0] out_row,
    output logic [$clog2(N/K):0] out_col
);

    localparam int NW = N / K;
    localparam int OW = $clog2(NW) + 1;

    state_t state;
    state_t state_nxt;
    pixel_t acc;
    logic   rd_vld_q;
    logic   first_q;
    logic   first_tap;
    logic   last_tap;
    logic   last_win;
    logic   win_hs;

    maxpool_addr_gen #(
        .N (N),
        .K (K),
        .AW(AW),
        .OW(OW)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .tap_adv  (rd_en),
        .win_adv  (win_hs),
        .rd_addr  (rd_addr),
        .wr       (out_row),
        .wc       (out_col),
        .first_tap(first_tap),
        .last_tap (last_tap),
        .last_win (last_win)
    );

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        rd_en     = (state == READ);
        out_valid = (state == OUT);
        out_data  = acc;
        win_hs    = out_valid && out_ready;
        case (state)
            IDLE: if (start) state_nxt = (NW == 0) ? DONE : READ;
            READ: if (last_tap) state_nxt = LAST;
            LAST: state_nxt = OUT;
            OUT:  if (out_ready) state_nxt = last_win ? DONE : READ;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // RAM data lags the strobe by one cycle; the delayed flags mark which beat is the window's first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_vld_q <= 1'b0;
            first_q  <= 1'b0;
            acc      <= '0;
        end else begin
            rd_vld_q <= rd_en;
            first_q  <= rd_en && first_tap;
            if (rd_vld_q) begin
                acc <= first_q ? rd_data : pixel_max(acc, rd_data);
            end
        end
    end

endmodule
